// File: rtl/upgrade_pkg.sv
// Shared types and helpers for the upgrade wallet: FSM state, level ceiling, saturating money math.
package upgrade_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

    function automatic int unsigned maxlvl(input int unsigned lvl_w);
        return (32'd1 << lvl_w) - 32'd1;
    endfunction

    // Sum is formed one bit wider than the operands and clamped to 2^w-1.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/upgrade_cost_table.sv
// Decodes per-channel next-level price, maxed flags and total passive income from packed levels.
module upgrade_cost_table
    import upgrade_pkg::*;
#(
    parameter int unsigned NUM_UPG     = 4,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned LVL_W       = 2,
    parameter int unsigned BASE_COST   = 10,
    parameter int unsigned INCOME_BASE = 1
) (
    input  logic [NUM_UPG*LVL_W-1:0] levels,
    output logic [NUM_UPG*BAL_W-1:0] unit_cost,
    output logic [NUM_UPG-1:0]       maxed,
    output logic [BAL_W-1:0]         income
);

    localparam logic [63:0]   BAL_MAX = (64'd1 << BAL_W) - 64'd1;
    localparam int unsigned   MAXL    = maxlvl(LVL_W);

    logic [LVL_W-1:0] lvl;
    logic [63:0]      price;
    logic [31:0]      acc;

    always_comb begin
        unit_cost = '0;
        maxed     = '0;
        lvl       = '0;
        price     = '0;
        acc       = 32'(INCOME_BASE);
        for (int unsigned i = 0; i < NUM_UPG; i++) begin
            lvl      = levels[i*LVL_W +: LVL_W];
            price    = 64'(BASE_COST * (i + 1)) << lvl;
            maxed[i] = (32'(lvl) == MAXL);
            // Shifts of BAL_W or more always overflow the balance width.
            if (maxed[i] || (32'(lvl) >= BAL_W) || (price > BAL_MAX))
                unit_cost[i*BAL_W +: BAL_W] = '1;
            else
                unit_cost[i*BAL_W +: BAL_W] = price[BAL_W-1:0];
            acc = sat_add(acc, 32'(lvl) * (i + 1), BAL_W);
        end
        income = acc[BAL_W-1:0];
    end

endmodule

// File: rtl/upgrade_wallet.sv
// Game balance plus NUM_UPG levelled upgrades with tick income and a check/commit buy FSM.
// Optional `define CLICK_EN adds a click input crediting CLICK_VALUE per pulse.
module upgrade_wallet
    import upgrade_pkg::*;
#(
    parameter int unsigned NUM_UPG     = 4,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned LVL_W       = 2,
    parameter int unsigned BASE_COST   = 10,
    parameter int unsigned INCOME_BASE = 1
`ifdef CLICK_EN
    ,
    parameter int unsigned CLICK_VALUE = 1
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     game_tick,
    input  logic [NUM_UPG-1:0]       buy_req,
`ifdef CLICK_EN
    input  logic                     click,
`endif
    output logic [BAL_W-1:0]         balance,
    output logic [NUM_UPG*LVL_W-1:0] levels,
    output logic [NUM_UPG*BAL_W-1:0] unit_cost,
    output logic [NUM_UPG-1:0]       maxed,
    output logic                     busy,
    output logic                     buy_succ,
    output logic                     buy_fail
);

    localparam int unsigned IDX_W = (NUM_UPG > 1) ? $clog2(NUM_UPG) : 1;

    state_t           state, next_state;
    logic [IDX_W-1:0] idx, pick;
    logic [BAL_W-1:0] income, cost_sel, balance_next;
    logic             maxed_sel, accept, fail_now, commit_now;
    logic [31:0]      base, credit;

    upgrade_cost_table #(
        .NUM_UPG    (NUM_UPG),
        .BAL_W      (BAL_W),
        .LVL_W      (LVL_W),
        .BASE_COST  (BASE_COST),
        .INCOME_BASE(INCOME_BASE)
    ) u_cost (
        .levels   (levels),
        .unit_cost(unit_cost),
        .maxed    (maxed),
        .income   (income)
    );

    assign cost_sel  = unit_cost[idx*BAL_W +: BAL_W];
    assign maxed_sel = maxed[idx];

    always_comb begin
        pick = '0;
        for (int unsigned i = NUM_UPG; i > 0; i--)
            if (buy_req[i-1]) pick = IDX_W'(i - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|buy_req) next_state = CHECK;
            CHECK:   next_state = (maxed_sel || (balance < cost_sel)) ? IDLE : COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Commit debit, tick income (pre-update levels) and click are folded into one saturating update.
    always_comb begin
        accept     = (state == IDLE) && (|buy_req);
        fail_now   = (state == CHECK) && (maxed_sel || (balance < cost_sel));
        commit_now = (state == COMMIT);
        base       = commit_now ? sat_sub(32'(balance), 32'(cost_sel)) : 32'(balance);
        credit     = game_tick ? 32'(income) : '0;
`ifdef CLICK_EN
        if (click) credit = credit + 32'(CLICK_VALUE);
`endif
        balance_next = BAL_W'(sat_add(base, credit, BAL_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            balance  <= '0;
            levels   <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            buy_succ <= 1'b0;
            buy_fail <= 1'b0;
        end else begin
            balance  <= balance_next;
            busy     <= (next_state != IDLE);
            buy_succ <= commit_now;
            buy_fail <= fail_now;
            if (accept) idx <= pick;
            if (commit_now)
                levels[idx*LVL_W +: LVL_W] <= levels[idx*LVL_W +: LVL_W] + LVL_W'(1);
        end
    end

endmodule

// File: tb/tb_upgrade_wallet.sv
// Self-checking bench for upgrade_wallet against a transaction-level wallet model.
module tb_upgrade_wallet;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        game_tick = 1'b0;
    logic [3:0]  buy_req = '0;
`ifdef CLICK_EN
    logic        click = 1'b0;
`endif
    logic [15:0] balance;
    logic [7:0]  levels;
    logic [63:0] unit_cost;
    logic [3:0]  maxed;
    logic        busy, buy_succ, buy_fail;

    int vectors    = 0;
    int miscompares = 0;

    int m_bal;
    int m_lvl [4];

    upgrade_wallet #(
        .NUM_UPG    (4),
        .BAL_W      (16),
        .LVL_W      (2),
        .BASE_COST  (10),
        .INCOME_BASE(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .game_tick(game_tick),
        .buy_req  (buy_req),
`ifdef CLICK_EN
        .click    (click),
`endif
        .balance  (balance),
        .levels   (levels),
        .unit_cost(unit_cost),
        .maxed    (maxed),
        .busy     (busy),
        .buy_succ (buy_succ),
        .buy_fail (buy_fail)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_income();
        int s = 1;
        for (int i = 0; i < 4; i++) s += m_lvl[i] * (i + 1);
        return s;
    endfunction

    function automatic int m_cost(input int i);
        int c;
        if (m_lvl[i] == 3) return 65535;
        c = 10 * (i + 1) * (2 ** m_lvl[i]);
        return (c > 65535) ? 65535 : c;
    endfunction

    function automatic logic [7:0] m_levels();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) v[i*2 +: 2] = 2'(m_lvl[i]);
        return v;
    endfunction

    function automatic logic [63:0] m_costs();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(m_cost(i));
        return v;
    endfunction

    function automatic logic [3:0] m_maxed();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (m_lvl[i] == 3);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1; game_tick = 1'b0; buy_req = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        m_bal = 0;
        for (int i = 0; i < 4; i++) m_lvl[i] = 0;
    endtask

    task automatic tick_n(input int n);
        game_tick = 1'b1;
        repeat (n) begin
            @(posedge clk);
            m_bal = (m_bal + m_income() > 65535) ? 65535 : m_bal + m_income();
        end
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    // Returns the edge count at which a result pulse was seen (-1 if none within bound).
    task automatic run_buy(input logic [3:0] req, output int lat, output bit succ);
        lat = -1; succ = 1'b0;
        buy_req = req;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) buy_req = '0;
            if (buy_succ || buy_fail) begin
                succ = buy_succ; lat = k;
                break;
            end
        end
    endtask

    task automatic model_buy(input logic [3:0] req, output bit succ);
        int i = 0;
        while (!req[i]) i++;
        succ = (m_lvl[i] < 3) && (m_bal >= m_cost(i));
        if (succ) begin
            m_bal -= m_cost(i);
            m_lvl[i]++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++;
        if (balance !== 16'd0 || busy !== 1'b0 || buy_succ !== 1'b0 || buy_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: bal=%0d busy=%b succ=%b fail=%b, want 0 0 0 0",
                     balance, busy, buy_succ, buy_fail);
        end
        vectors++;
        if (unit_cost !== {16'd40, 16'd30, 16'd20, 16'd10} || maxed !== 4'b0 || levels !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_costs: cost=%h maxed=%b lvl=%h, want 0028001e0014000a 0000 00",
                     unit_cost, maxed, levels);
        end
    endtask

    task automatic test_buy_success();
        int lat; bit succ, exp;
        do_reset();
        tick_n(10);
        model_buy(4'b0001, exp);
        run_buy(4'b0001, lat, succ);
        vectors++;
        if (!(succ === 1'b1 && lat == 3)) begin
            miscompares++;
            $display("FAIL buy_succ_latency: succ=%b lat=%0d, want succ=1 lat=3", succ, lat);
        end
        vectors++;
        if (balance !== 16'd0 || levels[1:0] !== 2'd1 || unit_cost[15:0] !== 16'd20) begin
            miscompares++;
            $display("FAIL buy_succ_state: bal=%0d lvl0=%0d cost0=%0d, want 0 1 20",
                     balance, levels[1:0], unit_cost[15:0]);
        end
        tick_n(1);
        vectors++;
        if (balance !== 16'd2) begin
            miscompares++;
            $display("FAIL income_after_buy: bal=%0d, want 2", balance);
        end
    endtask

    task automatic test_buy_fail();
        int lat; bit succ;
        do_reset();
        tick_n(5);
        run_buy(4'b0010, lat, succ);
        vectors++;
        if (!(succ === 1'b0 && lat == 2)) begin
            miscompares++;
            $display("FAIL buy_fail_latency: succ=%b lat=%0d, want succ=0 lat=2", succ, lat);
        end
        vectors++;
        if (balance !== 16'd5 || levels !== 8'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL buy_fail_state: bal=%0d lvl=%h busy=%b, want 5 00 0", balance, levels, busy);
        end
    endtask

    task automatic test_maxed();
        int lat; bit succ, exp;
        do_reset();
        tick_n(70);
        for (int k = 0; k < 3; k++) begin
            model_buy(4'b0001, exp);
            run_buy(4'b0001, lat, succ);
        end
        vectors++;
        if (maxed !== 4'b0001 || unit_cost[15:0] !== 16'hFFFF || levels[1:0] !== 2'd3 || balance !== 16'(m_bal)) begin
            miscompares++;
            $display("FAIL maxed_state: maxed=%b cost0=%h lvl0=%0d bal=%0d, want 0001 ffff 3 %0d",
                     maxed, unit_cost[15:0], levels[1:0], balance, m_bal);
        end
        tick_n(30);
        run_buy(4'b0001, lat, succ);
        vectors++;
        if (!(succ === 1'b0 && lat == 2) || balance !== 16'(m_bal) || levels !== m_levels()) begin
            miscompares++;
            $display("FAIL maxed_buy: succ=%b lat=%0d bal=%0d lvl=%h, want 0 2 %0d %h",
                     succ, lat, balance, levels, m_bal, m_levels());
        end
    endtask

    task automatic test_tick_on_commit();
        do_reset();
        tick_n(50);
        buy_req = 4'b0110;
        @(posedge clk); @(negedge clk);
        buy_req = '0;
        @(posedge clk); @(negedge clk);
        game_tick = 1'b1;
        @(posedge clk); @(negedge clk);
        game_tick = 1'b0;
        vectors++;
        if (buy_succ !== 1'b1 || balance !== 16'd31 || levels !== 8'b0000_0100) begin
            miscompares++;
            $display("FAIL tick_on_commit: succ=%b bal=%0d lvl=%b, want 1 31 00000100",
                     buy_succ, balance, levels);
        end
    endtask

    task automatic test_saturation_and_reset();
        int lat; bit succ, exp;
        int pulses = 0;
        do_reset();
        tick_n(22);
        model_buy(4'b0010, exp);
        run_buy(4'b0010, lat, succ);
        tick_n(21844);
        vectors++;
        if (balance !== 16'hFFFE || m_bal != 65534) begin
            miscompares++;
            $display("FAIL near_saturation: bal=%h model=%h, want fffe", balance, m_bal);
        end
        tick_n(1);
        vectors++;
        if (balance !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL saturate_tick: bal=%h, want ffff", balance);
        end
        tick_n(1);
        vectors++;
        if (balance !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL saturate_hold: bal=%h, want ffff", balance);
        end
        buy_req = 4'b0001;
        @(posedge clk); @(negedge clk);
        buy_req = '0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_check: busy=%b, want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        m_bal = 0;
        for (int i = 0; i < 4; i++) m_lvl[i] = 0;
        vectors++;
        if (balance !== 16'd0 || levels !== 8'h0 || busy !== 1'b0 || buy_succ !== 1'b0 || buy_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_buy: bal=%0d lvl=%h busy=%b succ=%b fail=%b, want 0 00 0 0 0",
                     balance, levels, busy, buy_succ, buy_fail);
        end
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (buy_succ || buy_fail) pulses++;
        end
        vectors++;
        if (pulses != 0 || balance !== 16'd0) begin
            miscompares++;
            $display("FAIL dropped_request: pulses=%0d bal=%0d, want 0 0", pulses, balance);
        end
    endtask

    task automatic test_random();
        int lat; bit succ, exp;
        logic [3:0] req;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                tick_n(int'($urandom_range(1, 40)));
            end else begin
                req = 4'($urandom_range(1, 15));
                model_buy(req, exp);
                run_buy(req, lat, succ);
                vectors++;
                if (succ !== exp || lat != (exp ? 3 : 2)) begin
                    miscompares++;
                    $display("FAIL rand_buy[%0d] req=%b: succ=%b lat=%0d, want succ=%b lat=%0d",
                             n, req, succ, lat, exp, exp ? 3 : 2);
                end
            end
            vectors++;
            if (balance !== 16'(m_bal) || levels !== m_levels() || unit_cost !== m_costs()
                || maxed !== m_maxed() || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: bal=%0d lvl=%h cost=%h maxed=%b busy=%b, want %0d %h %h %b 0",
                         n, balance, levels, unit_cost, maxed, busy, m_bal, m_levels(), m_costs(), m_maxed());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_buy_success();
        test_buy_fail();
        test_maxed();
        test_tick_on_commit();
        test_saturation_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
